// File: rtl/lvds_link_checker_if.sv
// lvds_link_checker_if: pattern, control and status bundle between the link checker and its host.
// With INJECT_ERR_EN defined the bundle also carries the inject_err request line.
interface lvds_link_checker_if #(
   parameter int DATA_W = 10,
   parameter int ERR_W  = 16
);
   logic              mode;
   logic              enable;
   logic              lock_n;
   logic              clr_err;
   logic [DATA_W-1:0] datarx;
   logic [DATA_W-1:0] datatx;
   logic              sync;
   logic [ERR_W-1:0]  err_cnt;
   logic              err_flag;
   logic [1:0]        state_o;
`ifdef INJECT_ERR_EN
   logic              inject_err;
   modport master (output mode, enable, lock_n, clr_err, datarx, inject_err,
                   input  datatx, sync, err_cnt, err_flag, state_o);
   modport slave  (input  mode, enable, lock_n, clr_err, datarx, inject_err,
                   output datatx, sync, err_cnt, err_flag, state_o);
`else
   modport master (output mode, enable, lock_n, clr_err, datarx,
                   input  datatx, sync, err_cnt, err_flag, state_o);
   modport slave  (input  mode, enable, lock_n, clr_err, datarx,
                   output datatx, sync, err_cnt, err_flag, state_o);
`endif
endinterface

// File: rtl/lvds_link_checker.sv
// lvds_link_checker: LVDS test-pattern generator (counter/PRBS7) with self-synchronising checker.
// Optional INJECT_ERR_EN: a rising edge on inject_err flips bit 0 of one transmitted word.
module lvds_link_checker #(
   parameter int DATA_W    = 10,
   parameter int ERR_W     = 16,
   parameter int LOCK_WAIT = 64,
   parameter int SYNC_GOOD = 8,
   parameter int SYNC_LOSS = 4
) (
   input logic sysclk,
   input logic rst_n,
   lvds_link_checker_if.slave link
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LOCK = 2'd1, SYNC = 2'd2, CHECK = 2'd3} state_t;
   localparam int LW = $clog2(LOCK_WAIT + 1);
   localparam int GW = $clog2(SYNC_GOOD + 1);
   localparam int BW = $clog2(SYNC_LOSS + 1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] pat, gen_word, rx_q, rx_p, pred;
   logic [6:0]        lfsr;
   logic [LW-1:0]     lock_cnt, lock_nx;
   logic [GW-1:0]     good_run, good_nx;
   logic [BW-1:0]     bad_run, bad_nx;
   logic [ERR_W-1:0]  err_cnt;
   logic              err_flag, sync, mode_q, reload, mismatch, err_hit;

   // Word produced by advancing a PRBS7 state DATA_W steps, first bit in the MSB.
   function automatic logic [DATA_W-1:0] prbs_word(input logic [6:0] seed);
      logic [6:0]        s;
      logic [DATA_W-1:0] w;
      s = seed;
      w = '0;
      for (int i = 0; i < DATA_W; i++) begin
         s = {s[5:0], s[6] ^ s[5]};
         w = {w[DATA_W-2:0], s[0]};
      end
      return w;
   endfunction

   assign reload   = (state == IDLE || state == WAIT_LOCK) && link.mode != mode_q;
   assign gen_word = prbs_word(lfsr);
   assign pred     = mode_q ? prbs_word(rx_p[6:0]) : rx_p + DATA_W'(1);
   // An all-zero PRBS seed would predict a locked-up LFSR, so it never counts as a match.
   assign mismatch = rx_q != pred || (mode_q && rx_p[6:0] == 7'd0);
   assign err_hit  = state == CHECK && mismatch;

   always_comb begin
      state_nx = state;
      lock_nx  = '0;
      good_nx  = '0;
      bad_nx   = '0;
      if (state == IDLE)
         state_nx = link.enable ? WAIT_LOCK : IDLE;
      else if (!link.enable)
         state_nx = IDLE;
      else if (link.lock_n)
         state_nx = WAIT_LOCK;
      else if (state == WAIT_LOCK) begin
         lock_nx  = lock_cnt == LW'(LOCK_WAIT - 1) ? '0 : lock_cnt + LW'(1);
         state_nx = lock_cnt == LW'(LOCK_WAIT - 1) ? SYNC : WAIT_LOCK;
      end else if (state == SYNC) begin
         good_nx  = mismatch ? '0 : good_run + GW'(1);
         state_nx = good_nx == GW'(SYNC_GOOD) ? CHECK : SYNC;
         good_nx  = good_nx == GW'(SYNC_GOOD) ? '0 : good_nx;
      end else begin
         bad_nx   = mismatch ? bad_run + BW'(1) : '0;
         state_nx = bad_nx == BW'(SYNC_LOSS) ? SYNC : CHECK;
         bad_nx   = bad_nx == BW'(SYNC_LOSS) ? '0 : bad_nx;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sync     <= 1'b0;
         pat      <= DATA_W'(1);
         lfsr     <= 7'h7F;
         mode_q   <= 1'b0;
         lock_cnt <= '0;
         good_run <= '0;
         bad_run  <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
         rx_q     <= '0;
         rx_p     <= '0;
      end else begin
         state    <= state_nx;
         sync     <= state_nx == CHECK;
         mode_q   <= reload ? link.mode : mode_q;
         pat      <= reload ? DATA_W'(1) : !link.enable ? pat : mode_q ? gen_word : pat + DATA_W'(1);
         lfsr     <= reload ? 7'h7F : (link.enable && mode_q) ? gen_word[6:0] : lfsr;
         lock_cnt <= lock_nx;
         good_run <= good_nx;
         bad_run  <= bad_nx;
         err_cnt  <= link.clr_err ? '0 : (err_hit && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
         err_flag <= err_hit || (err_flag && !link.clr_err);
         rx_q     <= link.datarx;
         rx_p     <= rx_q;
      end
   end

`ifdef INJECT_ERR_EN
   logic inject_q, flip;
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         inject_q <= 1'b0;
         flip     <= 1'b0;
      end else begin
         inject_q <= link.inject_err;
         flip     <= link.inject_err && !inject_q;
      end
   end
   assign link.datatx = {pat[DATA_W-1:1], pat[0] ^ flip};
`else
   assign link.datatx = pat;
`endif

   assign link.sync     = sync;
   assign link.err_cnt  = err_cnt;
   assign link.err_flag = err_flag;
   assign link.state_o  = state;
endmodule
